// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Turns the board reset pin and an asynchronous upstream lock indication
//   into a set of ordered, glitch-free fabric resets on clk_int.
//   After lock is seen, the block holds for HOLD_CYCLES cycles. It then
//   releases the reset bits one at a time, STAGE_GAP cycles apart.
//   Loss of lock or a soft reset request drops every stage together.
//
// Ports
//   clk_int        in   fabric clock
//   pin_rst_n      in   board reset, async active-low
//   lock_in        in   upstream lock/ready, async to clk_int
//   soft_rst       in   1-cycle synchronous request to re-run the sequence
//   rst_out_n      out  staged active-low resets, bit 0 releases first
//   ready          out  all stages released (RUN)
//   lock_loss_cnt  out  saturating count of lock drops seen in RUN

module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1024,
    parameter int NUM_STAGES  = 3,
    parameter int STAGE_GAP   = 16
) (
    input  logic                  clk_int,
    input  logic                  pin_rst_n,
    input  logic                  lock_in,
    input  logic                  soft_rst,
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  ready,
    output logic [7:0]            lock_loss_cnt
);

    localparam int MAXC = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

    typedef enum logic [2:0] {ASSERT, WAIT_LOCK, HOLD, RELEASE, RUN} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [NUM_STAGES-1:0] r_rst_out_n;
    logic                  r_ready;
    logic [7:0]            r_loss_cnt;
    // The FSM state register is the last flop of the deassert synchroniser.
    // ASSERT is left on the SYNC_STAGES-th edge after the pin releases.
    logic [SYNC_STAGES-2:0] r_rst_sync;
    logic [SYNC_STAGES-1:0] r_lock_sync;

    logic                  w_lock_s;
    logic                  w_rst_rel;
    logic                  w_abort;
    logic [NUM_STAGES-1:0] w_next_out;

    assign w_lock_s   = r_lock_sync[SYNC_STAGES-1];
    assign w_rst_rel  = r_rst_sync[SYNC_STAGES-2];
    assign w_abort    = !w_lock_s || soft_rst;
    // Next release pattern: shift one more 1 in from bit 0. In HOLD the
    // outputs are all 0, so this yields exactly bit 0.
    assign w_next_out = (r_rst_out_n << 1) | NUM_STAGES'(1);

    always_ff @(posedge clk_int or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES - 1; i++)
                r_rst_sync[i] <= r_rst_sync[i-1];
        end
    end

    always_ff @(posedge clk_int or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            r_lock_sync <= '0;
        end else begin
            r_lock_sync[0] <= lock_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_lock_sync[i] <= r_lock_sync[i-1];
        end
    end

    always_ff @(posedge clk_int or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            r_state     <= ASSERT;
            r_cnt       <= '0;
            r_rst_out_n <= '0;
            r_ready     <= 1'b0;
            r_loss_cnt  <= '0;
        end else begin
            case (r_state)
                ASSERT: begin
                    if (w_rst_rel) r_state <= WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    r_cnt       <= '0;
                    r_rst_out_n <= '0;
                    r_ready     <= 1'b0;
                    if (w_lock_s) r_state <= HOLD;
                end
                default: begin
                    if (w_abort) begin
                        r_state     <= WAIT_LOCK;
                        r_cnt       <= '0;
                        r_rst_out_n <= '0;
                        r_ready     <= 1'b0;
                        // Lock was high on entry to RUN, so lock_s low in RUN is a fall.
                        if (r_state == RUN && !w_lock_s && r_loss_cnt != 8'hFF)
                            r_loss_cnt <= r_loss_cnt + 8'd1;
                    end else if (r_state == HOLD || r_state == RELEASE) begin
                        if (r_cnt == ((r_state == HOLD) ? HOLD_LAST : GAP_LAST)) begin
                            r_cnt       <= '0;
                            r_rst_out_n <= w_next_out;
                            if (&w_next_out) begin
                                r_state <= RUN;
                                r_ready <= 1'b1;
                            end else begin
                                r_state <= RELEASE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign rst_out_n     = r_rst_out_n;
    assign ready         = r_ready;
    assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Directed bench for reset_sequencer (SYNC 2, HOLD 16, 3 stages, gap 4).
//   Expected output transitions are queued with their edge offset from the
//   stimulus event, then matched against each observed output change.

module tb_reset_sequencer;

    logic       clk_int = 1'b0;
    logic       pin_rst_n = 1'b1;
    logic       lock_in = 1'b1;
    logic       soft_rst = 1'b0;
    logic [2:0] rst_out_n;
    logic       ready;
    logic [7:0] lock_loss_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        string      tag;
        int         edge_n;
        logic [3:0] val;
    } exp_t;
    exp_t exp_q[$];

    reset_sequencer #(
        .SYNC_STAGES(2), .HOLD_CYCLES(16), .NUM_STAGES(3), .STAGE_GAP(4)
    ) dut (
        .clk_int      (clk_int),
        .pin_rst_n    (pin_rst_n),
        .lock_in      (lock_in),
        .soft_rst     (soft_rst),
        .rst_out_n    (rst_out_n),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk_int = ~clk_int;
    always @(posedge clk_int) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_int);
            #1;
        end
    endtask

    task automatic push(input string tag, input int e, input logic [3:0] v);
        exp_q.push_back('{tag, e, v});
    endtask

    task automatic wait_change(input int budget, output bit ok);
        logic [3:0] prev;
        prev = {ready, rst_out_n};
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_int);
            #1;
            if ({ready, rst_out_n} !== prev) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_int);
            #1;
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Pops each expected transition and matches it to the next output change.
    task automatic check_seq(input int base);
        exp_t e;
        bit   ok;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_change(100, ok);
            chk({e.tag, "_seen"}, 32'(ok), 32'd1);
            chk({e.tag, "_val"}, 32'({ready, rst_out_n}), 32'(e.val));
            chk({e.tag, "_edge"}, 32'(cyc - base), 32'(e.edge_n));
        end
    endtask

    task automatic push_seq(input string pfx, input int off);
        push({pfx, "_b0"}, off,     4'b0001);
        push({pfx, "_b1"}, off + 4, 4'b0011);
        push({pfx, "_run"}, off + 8, 4'b1111);
    endtask

    initial begin
        int  base;
        bit  ok;

        // Reset with no clock edge yet
        #1 pin_rst_n = 1'b0;
        #1;
        chk("rst_async", 32'({lock_loss_cnt, ready, rst_out_n}), 32'd0);
        tick(3);
        chk("rst_clocked", 32'({lock_loss_cnt, ready, rst_out_n}), 32'd0);

        // 1: lock steady, release pin
        base = cyc;
        pin_rst_n = 1'b1;
        push_seq("s1", 19);
        check_seq(base);
        chk("s1_cnt", 32'(lock_loss_cnt), 32'd0);

        // 3: drop lock in RUN for 5 cycles
        tick(3);
        base = cyc;
        lock_in = 1'b0;
        push("s3_abort", 3, 4'b0000);
        check_seq(base);
        chk("s3_cnt", 32'(lock_loss_cnt), 32'd1);
        tick(2);
        base = cyc;
        lock_in = 1'b1;
        push("s3_b0", 19, 4'b0001);
        push("s3_b1", 23, 4'b0011);
        check_seq(base);

        // 4: soft reset while rst_out_n = 011
        base = cyc;
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        chk("s4_abort", 32'({ready, rst_out_n}), 32'd0);
        chk("s4_cnt", 32'(lock_loss_cnt), 32'd1);
        push_seq("s4", 18);
        check_seq(base);

        // soft_rst and lock drop hit RUN on the same edge: one count
        base = cyc;
        lock_in = 1'b0;
        tick(2);
        soft_rst = 1'b1;
        push("sim_abort", 3, 4'b0000);
        check_seq(base);
        soft_rst = 1'b0;
        chk("sim_cnt", 32'(lock_loss_cnt), 32'd2);
        base = cyc;
        lock_in = 1'b1;
        push_seq("sim", 19);
        check_seq(base);

        // 5: 300 lock drops from RUN, counter saturates
        for (int i = 0; i < 300; i++) begin
            lock_in = 1'b0;
            tick(3);
            lock_in = 1'b1;
            wait_ready(100, ok);
            chk("s5_ready", 32'(ok), 32'd1);
        end
        chk("s5_sat", 32'(lock_loss_cnt), 32'd255);
        #2 pin_rst_n = 1'b0;
        #1;
        chk("s5_pin_async", 32'({lock_loss_cnt, ready, rst_out_n}), 32'd0);
        tick(2);

        // 2: lock low at release, raised 40 cycles later; soft_rst ignored in WAIT_LOCK
        lock_in = 1'b0;
        base = cyc;
        pin_rst_n = 1'b1;
        tick(20);
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        tick(19);
        chk("s2_wait", 32'({ready, rst_out_n}), 32'd0);
        base = cyc;
        lock_in = 1'b1;
        push_seq("s2", 19);
        check_seq(base);

        // Lock drop during HOLD is not counted
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        tick(5);
        lock_in = 1'b0;
        tick(4);
        lock_in = 1'b1;
        wait_ready(100, ok);
        chk("hold_drop_ready", 32'(ok), 32'd1);
        chk("hold_drop_cnt", 32'(lock_loss_cnt), 32'd0);

        // 6: pin reset mid-HOLD, then full re-sequence
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        tick(8);
        #2 pin_rst_n = 1'b0;
        #1;
        chk("s6_pin_async", 32'({lock_loss_cnt, ready, rst_out_n}), 32'd0);
        tick(2);
        base = cyc;
        pin_rst_n = 1'b1;
        push_seq("s6", 19);
        check_seq(base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
